// File: rtl/neuro_uio_tx.sv
// Bit-serial transmitter for uio_out[0]: byte FIFO in front of a framer that
// sends start(1), d0..d7 LSB first, stop(0), each bit CLKS_PER_BIT clocks long.
module neuro_uio_tx #(
  parameter int CLKS_PER_BIT = 4,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          tx_en,
  input  logic                          in_valid,
  input  logic [7:0]                    in_data,
  output logic                          in_ready,
  output logic [7:0]                    uio_out,
  output logic [7:0]                    uio_oe,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_DATA  = 2'd2;
  localparam logic [1:0] ST_STOP  = 2'd3;

  logic [1:0]    state;
  logic [BW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          line;

  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;

  logic fifo_empty;
  logic fifo_full;
  logic push;
  logic pop;
  logic baud_last;

  // Handshake: a byte transfers on any rising edge where in_valid and
  // in_ready are both high; in_ready depends only on registered occupancy.
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == CW'(FIFO_DEPTH));
  assign in_ready   = !rst && !fifo_full;
  assign push       = in_valid && in_ready;
  assign baud_last  = (baud_cnt == BW'(CLKS_PER_BIT - 1));
  // Pops only look at registered occupancy, so a byte never bypasses the FIFO.
  assign pop        = tx_en && !fifo_empty &&
                      ((state == ST_IDLE) || ((state == ST_STOP) && baud_last));

  assign busy       = (state != ST_IDLE);
  assign fifo_count = count;
  assign uio_out    = {7'b0, line};
  assign uio_oe     = {7'b0, !rst && (tx_en || busy)};

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= in_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= ST_IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shreg    <= '0;
      line     <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          baud_cnt <= '0;
          bit_cnt  <= '0;
          if (pop) begin
            state <= ST_START;
            shreg <= mem[rd_ptr];
            line  <= 1'b1;
          end
        end
        ST_START: begin
          if (baud_last) begin
            state    <= ST_DATA;
            baud_cnt <= '0;
            bit_cnt  <= '0;
            line     <= shreg[0];
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        ST_DATA: begin
          if (baud_last) begin
            baud_cnt <= '0;
            if (bit_cnt == 3'd7) begin
              state   <= ST_STOP;
              bit_cnt <= '0;
              line    <= 1'b0;
            end else begin
              bit_cnt <= bit_cnt + 3'd1;
              shreg   <= {1'b0, shreg[7:1]};
              line    <= shreg[1];
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
        default: begin
          if (baud_last) begin
            baud_cnt <= '0;
            bit_cnt  <= '0;
            // Chain straight into the next start bit when a byte is waiting.
            if (pop) begin
              state <= ST_START;
              shreg <= mem[rd_ptr];
              line  <= 1'b1;
            end else begin
              state <= ST_IDLE;
              line  <= 1'b0;
            end
          end else begin
            baud_cnt <= baud_cnt + BW'(1);
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_neuro_uio_tx.sv
// Bench for neuro_uio_tx: directed scenarios plus random bytes, with the line
// waveform predicted from the frame format and a queue of sent bytes.
module tb_neuro_uio_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic       clk;
  logic       rst;
  logic       tx_en;
  logic       in_valid;
  logic [7:0] in_data;
  logic       in_ready;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;
  logic       busy;
  logic [2:0] fifo_count;

  int checks;
  int errors;

  logic [7:0] exp_q[$];

  logic       cap_line [512];
  logic       cap_busy [512];
  logic [7:0] cap_oe   [512];
  logic [2:0] cap_cnt  [512];
  logic       cap_rdy  [512];

  neuro_uio_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk        (clk),
    .rst        (rst),
    .tx_en      (tx_en),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .uio_out    (uio_out),
    .uio_oe     (uio_oe),
    .busy       (busy),
    .fifo_count (fifo_count)
  );

  // Clock and reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst      = 1'b1;
    in_valid = 1'b0;
    tx_en    = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Records outputs at n consecutive falling edges; optionally drops
  // in_valid / tx_en right after sample drop_v / drop_e.
  task automatic capture(input int n, input int drop_v, input int drop_e);
    for (int i = 0; i < n; i++) begin
      cap_line[i] = uio_out[0];
      cap_busy[i] = busy;
      cap_oe[i]   = uio_oe;
      cap_cnt[i]  = fifo_count;
      cap_rdy[i]  = in_ready;
      if (i == drop_v) in_valid = 1'b0;
      if (i == drop_e) tx_en = 1'b0;
      @(negedge clk);
    end
  endtask

  // Reference: frames of exp_q sent back to back from cycle 0, then idle low.
  function automatic logic model_line(input int c);
    int f;
    int k;
    logic [7:0] b;
    f = c / FRAME;
    if (f >= exp_q.size()) return 1'b0;
    k = (c % FRAME) / CPB;
    b = exp_q[f];
    if (k == 0) return 1'b1;
    if (k == 9) return 1'b0;
    return b[k-1];
  endfunction

  function automatic logic model_busy(input int c);
    return (c < exp_q.size() * FRAME);
  endfunction

  task automatic test_reset();
    rst      = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hFF;
    tx_en    = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (uio_out !== 8'h00) begin errors++; $display("FAIL reset_uio_out got %h exp 00", uio_out); end
    checks++;
    if (uio_oe !== 8'h00) begin errors++; $display("FAIL reset_uio_oe got %h exp 00", uio_oe); end
    checks++;
    if (in_ready !== 1'b0) begin errors++; $display("FAIL reset_in_ready got %b exp 0", in_ready); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL reset_count got %0d exp 0", fifo_count); end
    rst      = 1'b0;
    in_valid = 1'b0;
    tx_en    = 1'b0;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd0) begin errors++; $display("FAIL post_reset_count got %0d exp 0", fifo_count); end
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL post_reset_ready got %b exp 1", in_ready); end
  endtask

  task automatic test_single();
    logic [9:0] exp_bits;
    int ones;
    exp_bits = 10'b0101001011;
    do_reset();
    exp_q.delete();
    exp_q.push_back(8'hA5);
    tx_en    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (uio_out[0] !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL single_no_bypass line %b busy %b exp 0 0", uio_out[0], busy);
    end
    checks++;
    if (fifo_count !== 3'd1) begin errors++; $display("FAIL single_count got %0d exp 1", fifo_count); end
    @(negedge clk);
    capture(44, -1, -1);
    ones = 0;
    for (int i = 0; i < 44; i++) begin
      if (cap_busy[i] === 1'b1) ones++;
      checks++;
      if (cap_line[i] !== model_line(i)) begin
        errors++; $display("FAIL single_line[%0d] got %b exp %b", i, cap_line[i], model_line(i));
      end
      checks++;
      if (cap_oe[i] !== 8'h01) begin errors++; $display("FAIL single_oe[%0d] got %h exp 01", i, cap_oe[i]); end
    end
    for (int k = 0; k < 10; k++) begin
      for (int j = 0; j < CPB; j++) begin
        checks++;
        if (cap_line[k*CPB+j] !== exp_bits[k]) begin
          errors++; $display("FAIL single_bit%0d got %b exp %b", k, cap_line[k*CPB+j], exp_bits[k]);
        end
      end
    end
    checks++;
    if (ones != 40) begin errors++; $display("FAIL single_busy_len got %0d exp 40", ones); end
  endtask

  task automatic test_back_to_back();
    int ones;
    do_reset();
    exp_q.delete();
    exp_q.push_back(8'h01);
    exp_q.push_back(8'h80);
    tx_en    = 1'b1;
    in_valid = 1'b1;
    in_data  = 8'h01;
    @(negedge clk);
    in_data  = 8'h80;
    @(negedge clk);
    in_valid = 1'b0;
    capture(84, -1, -1);
    ones = 0;
    for (int i = 0; i < 84; i++) begin
      if (cap_busy[i] === 1'b1) ones++;
      checks++;
      if (cap_line[i] !== model_line(i) || cap_busy[i] !== model_busy(i)) begin
        errors++; $display("FAIL b2b[%0d] line %b busy %b exp %b %b", i, cap_line[i], cap_busy[i],
                           model_line(i), model_busy(i));
      end
    end
    checks++;
    if (ones != 80) begin errors++; $display("FAIL b2b_busy_len got %0d exp 80", ones); end
    checks++;
    if (cap_line[39] !== 1'b0 || cap_line[40] !== 1'b1) begin
      errors++; $display("FAIL b2b_seam stop %b start %b exp 0 1", cap_line[39], cap_line[40]);
    end
    checks++;
    if (cap_line[40 + 8*CPB] !== 1'b1) begin
      errors++; $display("FAIL b2b_d7 got %b exp 1", cap_line[40 + 8*CPB]);
    end
  endtask

  task automatic test_full_fifo();
    logic [7:0] vals [5];
    vals[0] = 8'h11; vals[1] = 8'h22; vals[2] = 8'h33; vals[3] = 8'h44; vals[4] = 8'h55;
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 5; i++) exp_q.push_back(vals[i]);
    tx_en    = 1'b0;
    in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_data = vals[i];
      if (i < 4) @(negedge clk);
    end
    repeat ($urandom_range(1, 3)) begin
      checks++;
      if (fifo_count !== 3'd4 || in_ready !== 1'b0) begin
        errors++; $display("FAIL full_hold count %0d ready %b exp 4 0", fifo_count, in_ready);
      end
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL full_idle busy %b exp 0", busy); end
      @(negedge clk);
    end
    tx_en = 1'b1;
    @(negedge clk);
    checks++;
    if (fifo_count !== 3'd3 || in_ready !== 1'b1) begin
      errors++; $display("FAIL full_first_pop count %0d ready %b exp 3 1", fifo_count, in_ready);
    end
    capture(204, 1, -1);
    checks++;
    if (cap_cnt[1] !== 3'd4 || cap_rdy[1] !== 1'b0) begin
      errors++; $display("FAIL full_accept_55 count %0d ready %b exp 4 0", cap_cnt[1], cap_rdy[1]);
    end
    for (int i = 0; i < 204; i++) begin
      checks++;
      if (cap_line[i] !== model_line(i) || cap_busy[i] !== model_busy(i)) begin
        errors++; $display("FAIL full_order[%0d] line %b busy %b exp %b %b", i, cap_line[i], cap_busy[i],
                           model_line(i), model_busy(i));
      end
    end
    checks++;
    if (cap_cnt[203] !== 3'd0) begin errors++; $display("FAIL full_drain count %0d exp 0", cap_cnt[203]); end
  endtask

  task automatic test_tx_en_drop();
    logic [7:0] b0;
    logic [7:0] b1;
    b0 = 8'($urandom);
    b1 = 8'($urandom);
    do_reset();
    exp_q.delete();
    exp_q.push_back(b0);
    tx_en    = 1'b0;
    in_valid = 1'b1;
    in_data  = b0;
    @(negedge clk);
    in_data  = b1;
    @(negedge clk);
    in_valid = 1'b0;
    tx_en    = 1'b1;
    @(negedge clk);
    // d3 occupies cycles 16..19 of the frame
    capture(52, -1, 17);
    for (int i = 0; i < 52; i++) begin
      checks++;
      if (cap_line[i] !== model_line(i) || cap_busy[i] !== model_busy(i)) begin
        errors++; $display("FAIL drop[%0d] line %b busy %b exp %b %b", i, cap_line[i], cap_busy[i],
                           model_line(i), model_busy(i));
      end
      checks++;
      if (cap_oe[i] !== ((i < FRAME) ? 8'h01 : 8'h00)) begin
        errors++; $display("FAIL drop_oe[%0d] got %h exp %h", i, cap_oe[i], (i < FRAME) ? 8'h01 : 8'h00);
      end
    end
    checks++;
    if (cap_cnt[51] !== 3'd1) begin errors++; $display("FAIL drop_count got %0d exp 1", cap_cnt[51]); end
  endtask

  task automatic test_async_reset();
    do_reset();
    exp_q.delete();
    exp_q.push_back(8'($urandom));
    exp_q.push_back(8'($urandom));
    tx_en    = 1'b1;
    in_valid = 1'b1;
    in_data  = exp_q[0];
    @(negedge clk);
    in_data  = exp_q[1];
    @(negedge clk);
    in_valid = 1'b0;
    capture(21, -1, -1);
    for (int i = 0; i < 21; i++) begin
      checks++;
      if (cap_line[i] !== model_line(i)) begin
        errors++; $display("FAIL areset_pre[%0d] got %b exp %b", i, cap_line[i], model_line(i));
      end
    end
    #($urandom_range(1, 3));
    rst = 1'b1;
    #1;
    checks++;
    if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
      errors++; $display("FAIL areset_now out %h oe %h exp 00 00", uio_out, uio_oe);
    end
    checks++;
    if (busy !== 1'b0 || in_ready !== 1'b0 || fifo_count !== 3'd0) begin
      errors++; $display("FAIL areset_state busy %b ready %b count %0d exp 0 0 0", busy, in_ready, fifo_count);
    end
    @(negedge clk);
    rst = 1'b0;
    capture(45, -1, -1);
    for (int i = 0; i < 45; i++) begin
      checks++;
      if (cap_line[i] !== 1'b0 || cap_busy[i] !== 1'b0 || cap_cnt[i] !== 3'd0) begin
        errors++; $display("FAIL areset_post[%0d] line %b busy %b count %0d exp 0 0 0", i, cap_line[i],
                           cap_busy[i], cap_cnt[i]);
      end
    end
  endtask

  task automatic test_random();
    int n;
    for (int r = 0; r < 4; r++) begin
      do_reset();
      exp_q.delete();
      n = $urandom_range(1, DEPTH);
      tx_en    = 1'b0;
      in_valid = 1'b1;
      for (int i = 0; i < n; i++) begin
        in_data = 8'($urandom);
        exp_q.push_back(in_data);
        @(negedge clk);
      end
      in_valid = 1'b0;
      checks++;
      if (fifo_count !== 3'(n)) begin errors++; $display("FAIL rand_count got %0d exp %0d", fifo_count, n); end
      tx_en = 1'b1;
      @(negedge clk);
      capture(n * FRAME + 3, -1, -1);
      for (int i = 0; i < n * FRAME + 3; i++) begin
        checks++;
        if (cap_line[i] !== model_line(i) || cap_busy[i] !== model_busy(i)) begin
          errors++; $display("FAIL rand%0d[%0d] line %b busy %b exp %b %b", r, i, cap_line[i], cap_busy[i],
                             model_line(i), model_busy(i));
        end
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    rst      = 1'b1;
    tx_en    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    test_reset();
    test_single();
    test_back_to_back();
    test_full_fifo();
    test_tx_en_drop();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/neuro_uio_tx.md
# neuro_uio_tx

Serial transmitter that drives a single bit-serial line on `uio_out[0]` of the Tiny Tapeout bidirectional bank. It is the sending end of the one-wire link whose receiving end samples `uio_in[0]`. Upstream logic, such as the neuron core's spike or state reporter, pushes bytes through a valid/ready port into a small FIFO. The block frames each byte and shifts it out LSB-first at a fixed number of clocks per bit, and it owns the `uio_out`/`uio_oe` drive for the bank.

## Interface
- `CLKS_PER_BIT`, default 4: clock cycles per line bit; must be ≥1.
- `FIFO_DEPTH`, default 4: byte FIFO entries; power of two, ≥2.

Ports:
- `clk`  in  1  single clock; all state on rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `tx_en`  in  1  permits new frames to start; also requests pin drive.
- `in_valid`  in  1  upstream byte valid.
- `in_data`  in  8  upstream byte.
- `in_ready`  out  1  FIFO can accept; equals `!full`, and forced 0 while `rst` is high.
- `uio_out`  out  8  bit 0 is the serial line (registered); bits 7:1 are tied to 0.
- `uio_oe`  out  8  bit 0 = `tx_en | busy` (gated 0 during reset); bits 7:1 are tied to 0.
- `busy`  out  1  high in any state other than IDLE.
- `fifo_count`  out  $clog2(FIFO_DEPTH)+1  current occupancy, 0..FIFO_DEPTH.

## Operation
- Line idles low.
- Frame format: start bit = 1, then data bits d0..d7 LSB first, then stop bit = 0. The frame is 10 bits, or 10·CLKS_PER_BIT cycles.
- States and transitions:
  - IDLE: move to START when the FIFO is non-empty and `tx_en`=1. The byte is popped on the same edge.
  - START: after CLKS_PER_BIT cycles, move to DATA.
  - DATA: after 8·CLKS_PER_BIT cycles, move to STOP.
  - STOP: after CLKS_PER_BIT cycles, go to START if the FIFO is non-empty and `tx_en`=1 (popping on that edge, with no idle gap). Otherwise go to IDLE.
- Counters: bit counter runs 0..7 and baud counter runs 0..CLKS_PER_BIT-1. Both clear on every state entry.
- Shift register is loaded on pop and shifts right at the end of each data bit. The line register follows the current bit.
- FIFO:
  - Push on `in_valid & in_ready`.
  - Push and pop on the same edge leave `fifo_count` unchanged.
  - No bypass: a byte pushed into an empty FIFO is popped on the next edge at the earliest.
  - Ordering is strict FIFO, and read/write pointers wrap modulo FIFO_DEPTH.
- `tx_en` falling mid-frame: the current frame completes unchanged and no further frame starts. `uio_oe[0]` stays 1 until `busy` falls.
- `tx_en`=0 does not block pushes. The FIFO fills and `in_ready` drops at FIFO_DEPTH.
- Reset, asserted at any time:
  - State goes to IDLE and counters clear.
  - `uio_out` = 0, `uio_oe` = 0, `busy` = 0, `fifo_count` = 0, `in_ready` = 0.
  - FIFO contents are discarded, and a partially sent frame is truncated immediately.
  - Pushes attempted during reset are ignored.

## Timing
- A push on edge E0 into an empty FIFO with `tx_en`=1 and the block in IDLE causes a pop on E1. `uio_out[0]` = 1 after E1, so the start bit appears 1 cycle after the write edge.
- Each bit is held exactly CLKS_PER_BIT cycles.
- `busy` rises after E1 and falls after the edge that ends STOP, when no next byte is pending.
- Back-to-back frames are contiguous: the next start bit begins the cycle after the last stop-bit cycle.
- `in_ready` and `fifo_count` update the cycle after each push or pop edge.
- `in_ready` is never combinationally dependent on `in_valid`.

## Test plan
- Reset: hold `rst`=1 for 3 cycles with `in_valid`=1 and `in_data`=0xFF. Required: `uio_out`=0x00, `uio_oe`=0x00, `in_ready`=0, `busy`=0, `fifo_count`=0. After release, `fifo_count` is still 0.
- Single byte: CLKS_PER_BIT=4, `tx_en`=1, push 0xA5. Required:
  - the line reads 1,1,0,1,0,0,1,0,1,0, each bit 4 cycles, starting 1 cycle after the push edge;
  - `busy` is high for exactly 40 cycles;
  - `uio_oe`=0x01.
- Back-to-back: push 0x01 then 0x80 on consecutive cycles. Required: 80 contiguous cycles with no idle bit between the stop bit and the second start bit, and bit d7 of the second frame = 1.
- Full FIFO: with `tx_en`=0, push 0x11, 0x22, 0x33, 0x44, 0x55. Required:
  - the first 4 are accepted, then `fifo_count`=4 and `in_ready`=0, with 0x55 held;
  - when `tx_en` is raised, frames go out in order 0x11..0x44;
  - 0x55 is accepted the cycle after the first pop.
- `tx_en` drop: deassert during d3 of the first of two queued bytes. Required: the first frame completes, then IDLE with `fifo_count`=1, `uio_oe`=0x00, and the line at 0.
- Async reset mid-frame: assert `rst` between clock edges during d4. Required: `uio_out[0]`=0 immediately, and `fifo_count`=0 after release with no resumed frame.
